// File: rtl/mpu_cmd_pkg.sv
// rtl/mpu_cmd_pkg.sv - command codes, states, error codes and command table for the MPU_6050 sequencer
package mpu_cmd_pkg;

   localparam logic [3:0] CMD_CHECK     = 4'd1;
   localparam logic [3:0] CMD_TMP_MSR   = 4'd2;
   localparam logic [3:0] CMD_ACCEL_MSR = 4'd3;
   localparam logic [3:0] CMD_GYRO_MSR  = 4'd4;
   localparam logic [3:0] CMD_FIFO_EN   = 4'd5;
   localparam logic [3:0] CMD_FIFO_CNT  = 4'd6;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_BUS     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [7:0] CHIP_ID     = 8'h68;
   localparam logic [7:0] FIFO_EN_VAL = 8'hF8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROM_ADDR,
      ST_ROM_DATA,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } state_t;

   typedef struct packed {
      logic       legal;
      logic       rw;
      logic [2:0] nbytes;
      logic [7:0] wdata;
   } cmd_info_t;

   function automatic cmd_info_t cmd_lookup(input logic [3:0] code);
      cmd_info_t info;
      info = '{legal: 1'b1, rw: 1'b1, nbytes: 3'd1, wdata: 8'h00};
      case (code)
         CMD_CHECK:                   info.nbytes = 3'd1;
         CMD_TMP_MSR, CMD_FIFO_CNT:   info.nbytes = 3'd2;
         CMD_ACCEL_MSR, CMD_GYRO_MSR: info.nbytes = 3'd6;
         CMD_FIFO_EN: begin
            info.rw    = 1'b0;
            info.wdata = FIFO_EN_VAL;
         end
         default: info = '{legal: 1'b0, rw: 1'b0, nbytes: 3'd0, wdata: 8'h00};
      endcase
      return info;
   endfunction

endpackage

// File: rtl/mpu_cmd_sequencer_if.sv
// rtl/mpu_cmd_sequencer_if.sv - command, ROM and I2C master signal bundle of the MPU_6050 sequencer
interface mpu_cmd_sequencer_if #(
   parameter int ADDR_ROM_SZ = 4,
   parameter int DATA_ROM_SZ = 8,
   parameter int RES_SZ      = 48
);
   logic                   I_CMD_VALID;
   logic [ADDR_ROM_SZ-1:0] I_CMD;
   logic                   O_CMD_READY;
   logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM;
   logic [DATA_ROM_SZ-1:0] I_DATA_ROM;
   logic                   O_I2C_START;
   logic                   O_I2C_RW;
   logic [7:0]             O_I2C_REG;
   logic [7:0]             O_I2C_WDATA;
   logic [2:0]             O_I2C_NBYTES;
   logic                   I_I2C_BUSY;
   logic                   I_I2C_RD_VALID;
   logic [7:0]             I_I2C_RD_DATA;
   logic                   I_I2C_DONE;
   logic                   I_I2C_ACK_ERR;
   logic                   O_RES_VALID;
   logic [RES_SZ-1:0]      O_RES_DATA;
   logic                   O_CHIP_OK;
   logic                   O_ERR;
   logic [1:0]             O_ERR_CODE;

   modport master (
      input  I_CMD_VALID, I_CMD, I_DATA_ROM, I_I2C_BUSY, I_I2C_RD_VALID,
             I_I2C_RD_DATA, I_I2C_DONE, I_I2C_ACK_ERR,
      output O_CMD_READY, O_ADDR_ROM, O_I2C_START, O_I2C_RW, O_I2C_REG,
             O_I2C_WDATA, O_I2C_NBYTES, O_RES_VALID, O_RES_DATA, O_CHIP_OK,
             O_ERR, O_ERR_CODE
   );

   modport slave (
      output I_CMD_VALID, I_CMD, I_DATA_ROM, I_I2C_BUSY, I_I2C_RD_VALID,
             I_I2C_RD_DATA, I_I2C_DONE, I_I2C_ACK_ERR,
      input  O_CMD_READY, O_ADDR_ROM, O_I2C_START, O_I2C_RW, O_I2C_REG,
             O_I2C_WDATA, O_I2C_NBYTES, O_RES_VALID, O_RES_DATA, O_CHIP_OK,
             O_ERR, O_ERR_CODE
   );
endinterface

// File: rtl/mpu_timeout_cnt.sv
// rtl/mpu_timeout_cnt.sv - loadable down-counter flagging the cycle in which it reaches zero
module mpu_timeout_cnt #(
   parameter int TIMEOUT_CYC = 2_500_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST)
         cnt <= '0;
      else if (load)
         cnt <= CNT_W'(TIMEOUT_CYC);
      else if (en && cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   // Flag one cycle early so the owner leaves on the very edge the count hits zero.
   assign expired = en && (cnt == CNT_W'(1));
endmodule

// File: rtl/mpu_cmd_sequencer.sv
// rtl/mpu_cmd_sequencer.sv - serialises host commands into single MPU_6050 I2C transactions
module mpu_cmd_sequencer #(
   parameter int ADDR_ROM_SZ = 4,
   parameter int DATA_ROM_SZ = 8,
   parameter int RES_SZ      = 48,
   parameter int TIMEOUT_CYC = 2_500_000
) (
   input  logic                 CLK,
   input  logic                 RST,
   mpu_cmd_sequencer_if.master  bus
);
   import mpu_cmd_pkg::*;

   state_t                 state, state_nxt;
   cmd_info_t              info;
   logic [3:0]             lookup_code;
   logic                   cmd_accept, tmo_expired, rd_take, rd_short;
   logic [ADDR_ROM_SZ-1:0] addr_rom_q;
   logic [7:0]             i2c_reg_q, wdata_q;
   logic                   rw_q, chip_ok_q;
   logic [2:0]             nbytes_q, byte_cnt, cnt_next;
   logic [RES_SZ-1:0]      res_q;
   logic [1:0]             err_code_q, err_code_nxt;

   // One table lookup serves both the legality test in IDLE and the setup in ROM_DATA.
   assign lookup_code = (state == ST_IDLE) ? 4'(bus.I_CMD) : 4'(addr_rom_q);
   assign info        = cmd_lookup(lookup_code);
   assign cmd_accept  = bus.I_CMD_VALID && bus.O_CMD_READY;
   assign rd_take     = (state == ST_WAIT) && rw_q && bus.I_I2C_RD_VALID && (byte_cnt < nbytes_q);
   assign cnt_next    = byte_cnt + {2'b00, rd_take};
   assign rd_short    = rw_q && (cnt_next != nbytes_q);

   mpu_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .CLK     (CLK),
      .RST     (RST),
      .load    (bus.O_I2C_START),
      .en      (state == ST_WAIT),
      .expired (tmo_expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      err_code_nxt = err_code_q;
      case (state)
         ST_IDLE:
            if (cmd_accept) begin
               if (info.legal) state_nxt = ST_ROM_ADDR;
               else begin
                  state_nxt    = ST_ERR;
                  err_code_nxt = ERR_ILLEGAL;
               end
            end
         ST_ROM_ADDR: state_nxt = ST_ROM_DATA;
         ST_ROM_DATA: state_nxt = ST_ISSUE;
         ST_ISSUE:    if (!bus.I_I2C_BUSY) state_nxt = ST_WAIT;
         ST_WAIT:
            if (bus.I_I2C_DONE) begin
               if (bus.I_I2C_ACK_ERR || rd_short) begin
                  state_nxt    = ST_ERR;
                  err_code_nxt = ERR_BUS;
               end else
                  state_nxt = ST_RESP;
            end else if (tmo_expired) begin
               state_nxt    = ST_ERR;
               err_code_nxt = ERR_TIMEOUT;
            end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.O_CMD_READY = 1'b0;
      bus.O_I2C_START = 1'b0;
      bus.O_RES_VALID = 1'b0;
      bus.O_ERR       = 1'b0;
      case (state)
         ST_IDLE:  bus.O_CMD_READY = !RST;
         ST_ISSUE: bus.O_I2C_START = !bus.I_I2C_BUSY;
         ST_RESP:  bus.O_RES_VALID = 1'b1;
         ST_ERR:   bus.O_ERR       = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_rom_q <= '0;
         i2c_reg_q  <= '0;
         wdata_q    <= '0;
         rw_q       <= 1'b0;
         nbytes_q   <= '0;
         byte_cnt   <= '0;
         res_q      <= '0;
         chip_ok_q  <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         err_code_q <= err_code_nxt;
         if (cmd_accept) begin
            res_q    <= '0;
            byte_cnt <= '0;
            if (info.legal) addr_rom_q <= bus.I_CMD;
         end
         if (state == ST_ROM_DATA) begin
            i2c_reg_q <= 8'(bus.I_DATA_ROM);
            rw_q      <= info.rw;
            nbytes_q  <= info.nbytes;
            wdata_q   <= info.wdata;
         end
         if (rd_take) begin
            res_q    <= {res_q[RES_SZ-9:0], bus.I_I2C_RD_DATA};
            byte_cnt <= cnt_next;
         end
         if (state == ST_RESP && 4'(addr_rom_q) == CMD_CHECK)
            chip_ok_q <= (res_q[7:0] == CHIP_ID);
      end
   end

   assign bus.O_ADDR_ROM   = addr_rom_q;
   assign bus.O_I2C_RW     = rw_q;
   assign bus.O_I2C_REG    = i2c_reg_q;
   assign bus.O_I2C_WDATA  = wdata_q;
   assign bus.O_I2C_NBYTES = nbytes_q;
   assign bus.O_RES_DATA   = res_q;
   assign bus.O_CHIP_OK    = chip_ok_q;
   assign bus.O_ERR_CODE   = err_code_q;
endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
// tb/tb_mpu_cmd_sequencer.sv - randomized self-checking bench for mpu_cmd_sequencer against a transaction-level model
module tb_mpu_cmd_sequencer;
   localparam int TMO = 16;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   mpu_cmd_sequencer_if #(.ADDR_ROM_SZ(4), .DATA_ROM_SZ(8), .RES_SZ(48)) bus ();

   mpu_cmd_sequencer #(
      .ADDR_ROM_SZ(4), .DATA_ROM_SZ(8), .RES_SZ(48), .TIMEOUT_CYC(TMO)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   logic [7:0] rom [16];
   always @(posedge CLK) bus.I_DATA_ROM <= rom[bus.O_ADDR_ROM];

   int         checks   = 0;
   int         failures = 0;
   bit         chip_ok_m = 1'b0;
   logic [1:0] err_m     = 2'b00;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic exp_table(input logic [3:0] c, output bit legal, output bit rw,
                            output int nb, output logic [7:0] wd);
      legal = 1'b1; rw = 1'b1; wd = 8'h00; nb = 0;
      case (c)
         4'd1:       nb = 1;
         4'd2, 4'd6: nb = 2;
         4'd3, 4'd4: nb = 6;
         4'd5: begin rw = 1'b0; nb = 1; wd = 8'hF8; end
         default: begin legal = 1'b0; rw = 1'b0; end
      endcase
   endtask

   // mode: 0 normal DONE, 1 DONE with ACK_ERR, 2 master never signals DONE
   task automatic run_cmd(input logic [3:0] cmd, input int busy_cyc, input int mode,
                          input int nsend, input bit same_done, input logic [63:0] pat);
      bit          legal, rw, started;
      int          nb, k, exp_lat, exp_err, j;
      logic [7:0]  wd;
      logic [47:0] exp_res;

      exp_table(cmd, legal, rw, nb, wd);
      exp_res = '0;
      if (rw)
         for (int i = 0; i < nsend && i < nb; i++)
            exp_res = (exp_res << 8) | 48'(pat[63-8*i -: 8]);
      if (!legal)                 exp_err = 1;
      else if (mode == 2)         exp_err = 3;
      else if (mode == 1)         exp_err = 2;
      else if (rw && nsend < nb)  exp_err = 2;
      else                        exp_err = 0;

      k = 0;
      while (!bus.O_CMD_READY && k < 50) begin @(negedge CLK); k++; end
      if (!bus.O_CMD_READY) check_eq("ready_wait", bus.O_CMD_READY, 1);

      bus.I_CMD_VALID = 1'b1;
      bus.I_CMD       = cmd;
      bus.I_I2C_BUSY  = (busy_cyc > 0);
      @(negedge CLK);
      bus.I_CMD_VALID = 1'b0;

      if (legal) begin
         k = 0; started = 1'b0;
         while (!started && k < 40) begin
            if (k >= busy_cyc) bus.I_I2C_BUSY = 1'b0;
            #1;
            if (bus.O_I2C_START) started = 1'b1;
            else begin @(negedge CLK); k++; end
         end
         if (!started) begin
            check_eq("start_seen", 0, 1);
            return;
         end
         exp_lat = (busy_cyc + 1 > 3) ? busy_cyc + 1 : 3;
         check_eq("start_latency", k + 1, exp_lat);
         check_eq("i2c_reg", bus.O_I2C_REG, rom[cmd]);
         check_eq("i2c_rw", bus.O_I2C_RW, rw);
         check_eq("i2c_nbytes", bus.O_I2C_NBYTES, nb);
         if (!rw) check_eq("i2c_wdata", bus.O_I2C_WDATA, wd);
         @(negedge CLK);

         if (mode == 2) begin
            j = 1;
            while (!bus.O_ERR && j < TMO + 10) begin @(negedge CLK); j++; end
            check_eq("timeout_latency", j, TMO + 1);
         end else begin
            for (int i = 0; i < nsend; i++) begin
               bus.I_I2C_RD_VALID = 1'b1;
               bus.I_I2C_RD_DATA  = pat[63-8*i -: 8];
               if (same_done && i == nsend - 1) begin
                  bus.I_I2C_DONE    = 1'b1;
                  bus.I_I2C_ACK_ERR = (mode == 1);
               end
               @(negedge CLK);
            end
            bus.I_I2C_RD_VALID = 1'b0;
            if (!(same_done && nsend > 0)) begin
               bus.I_I2C_DONE    = 1'b1;
               bus.I_I2C_ACK_ERR = (mode == 1);
               @(negedge CLK);
            end
            bus.I_I2C_DONE    = 1'b0;
            bus.I_I2C_ACK_ERR = 1'b0;
         end
      end else begin
         #1;
         check_eq("illegal_no_start", bus.O_I2C_START, 0);
      end

      check_eq("res_valid", bus.O_RES_VALID, exp_err == 0);
      check_eq("err_pulse", bus.O_ERR, exp_err != 0);
      if (exp_err == 0) check_eq("res_data", bus.O_RES_DATA, exp_res);
      else              check_eq("err_code", bus.O_ERR_CODE, exp_err);

      if (exp_err == 0 && cmd == 4'd1) chip_ok_m = (exp_res[7:0] == 8'h68);
      if (exp_err != 0) err_m = 2'(exp_err);

      @(negedge CLK);
      check_eq("res_valid_end", bus.O_RES_VALID, 0);
      check_eq("err_end", bus.O_ERR, 0);
      check_eq("ready_after", bus.O_CMD_READY, 1);
      check_eq("chip_ok_held", bus.O_CHIP_OK, chip_ok_m);
      check_eq("err_code_held", bus.O_ERR_CODE, err_m);
   endtask

   initial begin
      int         k, mode, nsend, busy;
      bit         legal, rw;
      int         nb;
      logic [7:0] wd;
      logic [3:0] cmd;
      logic [63:0] pat;

      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      rom[1] = 8'h75;
      rom[3] = 8'h3B;
      bus.I_CMD_VALID = 1'b0; bus.I_CMD = '0; bus.I_I2C_BUSY = 1'b0;
      bus.I_I2C_RD_VALID = 1'b0; bus.I_I2C_RD_DATA = '0;
      bus.I_I2C_DONE = 1'b0; bus.I_I2C_ACK_ERR = 1'b0;

      repeat (3) @(negedge CLK);
      check_eq("ready_in_reset", bus.O_CMD_READY, 0);
      RST = 1'b0;
      @(negedge CLK);
      check_eq("rst_ready", bus.O_CMD_READY, 1);
      check_eq("rst_start", bus.O_I2C_START, 0);
      check_eq("rst_res_valid", bus.O_RES_VALID, 0);
      check_eq("rst_err", bus.O_ERR, 0);
      check_eq("rst_chip_ok", bus.O_CHIP_OK, 0);
      check_eq("rst_err_code", bus.O_ERR_CODE, 0);
      check_eq("rst_res_data", bus.O_RES_DATA, 0);
      check_eq("rst_i2c_reg", bus.O_I2C_REG, 0);

      run_cmd(4'd1, 0, 0, 1, 1'b1, 64'h6800_0000_0000_0000);
      run_cmd(4'd3, 0, 0, 6, 1'b1, 64'h0102_0304_0506_0000);
      run_cmd(4'd5, 5, 0, 0, 1'b0, 64'h0);
      run_cmd(4'hA, 0, 0, 0, 1'b0, 64'h0);
      run_cmd(4'd2, 0, 1, 2, 1'b0, 64'h1234_0000_0000_0000);
      run_cmd(4'd4, 0, 2, 0, 1'b0, 64'h0);
      run_cmd(4'd6, 0, 0, 3, 1'b0, 64'hAABB_CC00_0000_0000);
      run_cmd(4'd3, 0, 0, 5, 1'b1, 64'h1122_3344_5500_0000);

      // Reset while waiting on the bus, then a stale DONE arrives.
      bus.I_CMD_VALID = 1'b1; bus.I_CMD = 4'd4;
      @(negedge CLK);
      bus.I_CMD_VALID = 1'b0;
      k = 0;
      while (!bus.O_I2C_START && k < 10) begin @(negedge CLK); k++; end
      check_eq("rst_test_start", bus.O_I2C_START, 1);
      @(negedge CLK);
      bus.I_I2C_RD_VALID = 1'b1; bus.I_I2C_RD_DATA = 8'h55;
      @(negedge CLK);
      bus.I_I2C_RD_VALID = 1'b0;
      RST = 1'b1;
      #1;
      check_eq("ready_mid_reset", bus.O_CMD_READY, 0);
      @(negedge CLK);
      RST = 1'b0;
      bus.I_I2C_DONE = 1'b1;
      @(negedge CLK);
      bus.I_I2C_DONE = 1'b0;
      chip_ok_m = 1'b0; err_m = 2'b00;
      for (int i = 0; i < 4; i++) begin
         check_eq("late_done_res", bus.O_RES_VALID, 0);
         check_eq("late_done_err", bus.O_ERR, 0);
         @(negedge CLK);
      end
      check_eq("post_rst_ready", bus.O_CMD_READY, 1);
      check_eq("post_rst_chip_ok", bus.O_CHIP_OK, 0);
      check_eq("post_rst_err_code", bus.O_ERR_CODE, 0);
      run_cmd(4'd1, 0, 0, 1, 1'b0, 64'h6800_0000_0000_0000);

      for (int n = 0; n < 40; n++) begin
         cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
         exp_table(cmd, legal, rw, nb, wd);
         busy = int'($urandom_range(0, 4));
         k    = int'($urandom_range(0, 9));
         mode = (k == 0) ? 1 : (k == 1) ? 2 : 0;
         nsend = rw ? nb - 1 + int'($urandom_range(0, 2)) : 0;
         pat = {$urandom, $urandom};
         if (cmd == 4'd1 && $urandom_range(0, 1) == 1) pat[63:56] = 8'h68;
         run_cmd(cmd, busy, mode, nsend, 1'($urandom_range(0, 1)), pat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mpu_cmd_sequencer.md
Name: mpu_cmd_sequencer

Overview:
- Command sequencer between the host-side command source, the MPU_6050 instruction ROM and the I2C master.
- Accepts one 4-bit command code and uses it as the ROM word address to fetch the MPU_6050 register address.
- Issues one I2C transaction (burst read or single write), assembles the returned bytes and reports a result or error.
- Serialises all MPU_6050 accesses so only one transaction is in flight.

Parameters:
- ADDR_ROM_SZ, 4, ROM address width; equals command code width.
- DATA_ROM_SZ, 8, ROM word width; MPU_6050 register address width.
- RES_SZ, 48, result width; holds up to 6 bytes.
- TIMEOUT_CYC, 2_500_000, cycles allowed from O_I2C_START to I_I2C_DONE (50 ms at 50 MHz).

Ports:
- CLK  in  1  clock 50 MHz
- RST  in  1  synchronous active-high reset
- I_CMD_VALID  in  1  command request
- I_CMD  in  ADDR_ROM_SZ  command code (CHECK=1 .. FIFO_CNT=6)
- O_CMD_READY  out  1  sequencer idle; command accepted on VALID&READY
- O_ADDR_ROM  out  ADDR_ROM_SZ  ROM word address, registered
- I_DATA_ROM  in  DATA_ROM_SZ  ROM word; valid one cycle after address sampled
- O_I2C_START  out  1  one-cycle transaction start pulse
- O_I2C_RW  out  1  1=read, 0=write
- O_I2C_REG  out  8  MPU_6050 register address
- O_I2C_WDATA  out  8  write byte
- O_I2C_NBYTES  out  3  read byte count (1..6)
- I_I2C_BUSY  in  1  master busy
- I_I2C_RD_VALID  in  1  one read byte valid
- I_I2C_RD_DATA  in  8  read byte
- I_I2C_DONE  in  1  transaction complete pulse
- I_I2C_ACK_ERR  in  1  NACK seen; valid with DONE
- O_RES_VALID  out  1  one-cycle result pulse
- O_RES_DATA  out  RES_SZ  assembled bytes, first byte most significant, right-justified
- O_CHIP_OK  out  1  CHECK result: read byte == 8'h68; held until next CHECK
- O_ERR  out  1  one-cycle error pulse (mutually exclusive with O_RES_VALID)
- O_ERR_CODE  out  2  01 illegal cmd, 10 bus error, 11 timeout; held until next error

Behaviour:
- Reset: state IDLE; all outputs 0 except O_CMD_READY (0 during RST, 1 first cycle after). Reset mid-transaction aborts immediately; a late I_I2C_DONE/RD_VALID in IDLE is ignored.
- States and transitions:
  - IDLE: O_CMD_READY=1. On VALID, latch cmd, clear result register and byte counter. Legal cmd -> ROM_ADDR (O_ADDR_ROM<=cmd). Illegal (0, 7..15) -> ERR (code 01).
  - ROM_ADDR: one cycle; ROM samples address -> ROM_DATA.
  - ROM_DATA: latch I_DATA_ROM into O_I2C_REG; set RW/NBYTES/WDATA from command table -> ISSUE.
  - ISSUE: wait while I_I2C_BUSY=1. When 0, pulse O_I2C_START for one cycle, load timeout counter -> WAIT.
  - WAIT: each RD_VALID shifts in: res <= {res[RES_SZ-9:0], byte}, count++. Bytes beyond NBYTES are ignored and not counted.
    - DONE with ACK_ERR=1, or read count != NBYTES -> ERR (code 10).
    - DONE otherwise -> RESP.
    - Counter reaching 0 -> ERR (code 11).
    - RD_VALID and DONE in the same cycle: the byte is counted before the DONE check.
    - DONE and timeout expiry in the same cycle: DONE wins.
  - RESP: O_RES_VALID=1 one cycle; for CHECK also update O_CHIP_OK -> IDLE.
  - ERR: O_ERR=1 one cycle -> IDLE.
- Command table:
  - CHECK: read 1
  - TMP_MSR: read 2
  - ACCEL_MSR: read 6
  - GYRO_MSR: read 6
  - FIFO_EN: write 1, data 8'hF8
  - FIFO_CNT: read 2
- Write results: O_RES_DATA=0 with O_RES_VALID.
- Latency: O_I2C_START is earliest 3 cycles after the accept edge. RESP is 1 cycle after DONE.
- O_I2C_REG/RW/NBYTES/WDATA hold stable from ROM_DATA until the next command.

Decomposition:
- Package mpu_cmd_pkg:
  - command code constants (CHECK..FIFO_CNT)
  - state enum
  - error code constants
  - CHIP_ID=8'h68, FIFO_EN_VAL=8'hF8
  - command table function (code -> rw, nbytes, wdata)
- Optional sub-module mpu_timeout_cnt: loadable down-counter with expiry flag.

Test Plan:
- Reset, then CHECK; ROM[1]=8'h75; master returns 8'h68 -> O_I2C_REG=8'h75, NBYTES=1, RES_VALID with O_RES_DATA=48'h68, O_CHIP_OK=1.
- ACCEL_MSR, ROM[3]=8'h3B; bytes 01..06, one with DONE in the same cycle -> O_RES_DATA=48'h010203040506.
- FIFO_EN with I_I2C_BUSY held for 5 cycles -> START delayed until BUSY=0; RW=0, O_I2C_WDATA=8'hF8; RES_VALID, data 0.
- I_CMD=4'hA -> O_ERR, code 01, no START. TMP_MSR with DONE+ACK_ERR -> code 10. GYRO with no DONE, TIMEOUT_CYC=16 -> code 11 after 16 cycles.
- RST asserted in WAIT, then late DONE -> no RES_VALID/ERR; O_CMD_READY=1; next CHECK completes normally.
